// File: rtl/r_type_decoder_pkg.sv
// Shared operation enumeration and R-type funct field encodings.
// Package name is opcode_type; the M-extension enumerators exist regardless of RV32M_EN.
package opcode_type;

  typedef enum logic [4:0] {
    rak_add    = 5'd0,
    rak_sub    = 5'd1,
    rak_sll    = 5'd2,
    rak_slt    = 5'd3,
    rak_sltu   = 5'd4,
    rak_xor    = 5'd5,
    rak_srl    = 5'd6,
    rak_sra    = 5'd7,
    rak_or     = 5'd8,
    rak_and    = 5'd9,
    rak_mul    = 5'd10,
    rak_mulh   = 5'd11,
    rak_mulhsu = 5'd12,
    rak_mulhu  = 5'd13,
    rak_div    = 5'd14,
    rak_divu   = 5'd15,
    rak_rem    = 5'd16,
    rak_remu   = 5'd17
  } reg_arith_kind_t;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SRL  = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

endpackage

// File: rtl/r_type_decoder_comb.sv
// Pure combinational funct7/funct3 -> operation kind table.
// Define RV32M_EN to decode the funct7=0000001 multiply/divide row.
module r_type_decode_comb
  import opcode_type::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  output reg_arith_kind_t kind_o,
  output logic            illegal_o
);

  // Table lookup; every unlisted encoding falls back to add with illegal set
  always_comb begin
    kind_o    = rak_add;
    illegal_o = 1'b0;
    case (funct7_i)
      FUNCT7_BASE: begin
        case (funct3_i)
          FUNCT3_ADD:  kind_o = rak_add;
          FUNCT3_SLL:  kind_o = rak_sll;
          FUNCT3_SLT:  kind_o = rak_slt;
          FUNCT3_SLTU: kind_o = rak_sltu;
          FUNCT3_XOR:  kind_o = rak_xor;
          FUNCT3_SRL:  kind_o = rak_srl;
          FUNCT3_OR:   kind_o = rak_or;
          FUNCT3_AND:  kind_o = rak_and;
          default:     kind_o = rak_add;
        endcase
      end
      FUNCT7_ALT: begin
        case (funct3_i)
          FUNCT3_ADD: kind_o = rak_sub;
          FUNCT3_SRL: kind_o = rak_sra;
          default: begin
            kind_o    = rak_add;
            illegal_o = 1'b1;
          end
        endcase
      end
`ifdef RV32M_EN
      FUNCT7_MULDIV: begin
        case (funct3_i)
          FUNCT3_MUL:    kind_o = rak_mul;
          FUNCT3_MULH:   kind_o = rak_mulh;
          FUNCT3_MULHSU: kind_o = rak_mulhsu;
          FUNCT3_MULHU:  kind_o = rak_mulhu;
          FUNCT3_DIV:    kind_o = rak_div;
          FUNCT3_DIVU:   kind_o = rak_divu;
          FUNCT3_REM:    kind_o = rak_rem;
          FUNCT3_REMU:   kind_o = rak_remu;
          default:       kind_o = rak_add;
        endcase
      end
`endif
      default: begin
        kind_o    = rak_add;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/r_type_decoder.sv
// R-type ALU operation decoder with one registered output stage.
// Optional macro RV32M_EN enables the M-extension row in r_type_decode_comb.
module r_type_decoder
  import opcode_type::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output reg_arith_kind_t kind,
  output logic            valid_o,
  output logic            illegal
);

  reg_arith_kind_t dec_kind_s;
  logic            dec_illegal_s;

  reg_arith_kind_t kind_d, kind_q;
  logic            illegal_d, illegal_q;
  logic            valid_d, valid_q;

  r_type_decode_comb u_decode (
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .kind_o    (dec_kind_s),
    .illegal_o (dec_illegal_s)
  );

  // Next state: capture the decode on valid, otherwise hold kind/illegal
  always_comb begin
    kind_d    = kind_q;
    illegal_d = illegal_q;
    valid_d   = valid_i;
    if (valid_i) begin
      kind_d    = dec_kind_s;
      illegal_d = dec_illegal_s;
    end else begin
      kind_d    = kind_q;
      illegal_d = illegal_q;
    end
  end

  // Output register; synchronous reset dominates valid_i
  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q    <= rak_add;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      kind_q    <= kind_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
    end
  end

  assign kind    = kind_q;
  assign illegal = illegal_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_r_type_decoder.sv
// Self-checking bench: directed vector table, then random stimulus against a reference model.
module tb_r_type_decoder;
  import opcode_type::*;

  logic            clk;
  logic            rst;
  logic            valid_i;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  reg_arith_kind_t kind;
  logic            valid_o;
  logic            illegal;

  int total;
  int bad;

  r_type_decoder dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .funct3  (funct3),
    .funct7  (funct7),
    .kind    (kind),
    .valid_o (valid_o),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            rst;
    logic            vld;
    logic [6:0]      f7;
    logic [2:0]      f3;
    reg_arith_kind_t exp_kind;
    logic            exp_valid;
    logic            exp_ill;
  } vec_t;

  vec_t vecs [20];

  // Reference: meaning of each R-type encoding straight from the ISA tables
  reg_arith_kind_t base_map [8];
  reg_arith_kind_t m_map [8];

  // Model state: what the registered outputs must show
  reg_arith_kind_t m_kind;
  logic            m_valid;
  logic            m_ill;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_cycle(input logic r, input logic v, input logic [6:0] f7,
                             input logic [2:0] f3);
    rst     = r;
    valid_i = v;
    funct7  = f7;
    funct3  = f3;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic r, input logic v, input logic [6:0] f7,
                            input logic [2:0] f3);
    bit leg;
    reg_arith_kind_t k;
    leg = 1'b1;
    k   = rak_add;
    if (f7 == 7'd0) begin
      k = base_map[f3];
    end else if (f7 == 7'd32 && f3 == 3'd0) begin
      k = rak_sub;
    end else if (f7 == 7'd32 && f3 == 3'd5) begin
      k = rak_sra;
`ifdef RV32M_EN
    end else if (f7 == 7'd1) begin
      k = m_map[f3];
`endif
    end else begin
      leg = 1'b0;
    end
    if (r) begin
      m_kind  = rak_add;
      m_valid = 1'b0;
      m_ill   = 1'b0;
    end else if (v) begin
      m_kind  = leg ? k : rak_add;
      m_ill   = ~leg;
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    reg_arith_kind_t m_div_kind;
    logic            m_div_ill;
    total = 0;
    bad   = 0;

    base_map[0] = rak_add;  base_map[1] = rak_sll;  base_map[2] = rak_slt;
    base_map[3] = rak_sltu; base_map[4] = rak_xor;  base_map[5] = rak_srl;
    base_map[6] = rak_or;   base_map[7] = rak_and;
    m_map[0] = rak_mul;  m_map[1] = rak_mulh; m_map[2] = rak_mulhsu; m_map[3] = rak_mulhu;
    m_map[4] = rak_div;  m_map[5] = rak_divu; m_map[6] = rak_rem;    m_map[7] = rak_remu;

`ifdef RV32M_EN
    m_div_kind = rak_div;
    m_div_ill  = 1'b0;
`else
    m_div_kind = rak_add;
    m_div_ill  = 1'b1;
`endif

    vecs[0]  = '{1'b1, 1'b0, 7'h00, 3'd0, rak_add,    1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 7'h00, 3'd0, rak_add,    1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 7'h00, 3'd0, rak_add,    1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 7'h00, 3'd1, rak_sll,    1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 7'h00, 3'd2, rak_slt,    1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 7'h00, 3'd3, rak_sltu,   1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 7'h00, 3'd4, rak_xor,    1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 7'h00, 3'd5, rak_srl,    1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 7'h00, 3'd6, rak_or,     1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 7'h00, 3'd7, rak_and,    1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 7'h20, 3'd0, rak_sub,    1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 7'h20, 3'd5, rak_sra,    1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 7'h20, 3'd1, rak_add,    1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 7'h01, 3'd4, m_div_kind, 1'b1, m_div_ill};
    vecs[14] = '{1'b0, 1'b1, 7'h7f, 3'd0, rak_add,    1'b1, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 7'h00, 3'd7, rak_and,    1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 7'h00, 3'd0, rak_and,    1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 7'h7f, 3'd0, rak_and,    1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 7'h7f, 3'd3, rak_add,    1'b1, 1'b1};
    vecs[19] = '{1'b1, 1'b1, 7'h20, 3'd0, rak_add,    1'b0, 1'b0};

    rst = 1'b1; valid_i = 1'b0; funct7 = 7'd0; funct3 = 3'd0;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      drive_cycle(vecs[i].rst, vecs[i].vld, vecs[i].f7, vecs[i].f3);
      check($sformatf("vec%0d_kind", i), int'(kind), int'(vecs[i].exp_kind));
      check($sformatf("vec%0d_valid", i), int'(valid_o), int'(vecs[i].exp_valid));
      check($sformatf("vec%0d_illegal", i), int'(illegal), int'(vecs[i].exp_ill));
    end

    // Random phase; model starts from the reset state left by the last vector
    m_kind = rak_add; m_valid = 1'b0; m_ill = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic r, v;
      logic [6:0] f7;
      logic [2:0] f3;
      logic [31:0] rnd;
      rnd = $urandom;
      r  = ($urandom_range(0, 19) == 0);
      v  = ($urandom_range(0, 3) != 0);
      f3 = rnd[2:0];
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = rnd[13:7];
      endcase
      drive_cycle(r, v, f7, f3);
      model_step(r, v, f7, f3);
      check($sformatf("rnd%0d_kind", n), int'(kind), int'(m_kind));
      check($sformatf("rnd%0d_valid", n), int'(valid_o), int'(m_valid));
      check($sformatf("rnd%0d_illegal", n), int'(illegal), int'(m_ill));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
